// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and codes for the multicycle RISC-V style control unit:
// FSM states, opcodes and the encodings of the datapath select fields.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format depends only on the opcode, never on the FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        if (op == OP_STORE)
            imm = IMM_S;
        else if (op == OP_BRANCH)
            imm = IMM_B;
        else if (op == OP_JAL)
            imm = IMM_J;
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the instruction/datapath side (master) and the controller (slave).
interface multicycle_ctrl_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       mem_req;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal, state
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal, state
    );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from funct3; subtraction only when the
// controller says the instruction is an R-type with funct7 bit 5 set.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       sub_req_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_control_o = sub_req_i ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control_o = ALU_SLT;
            3'b110:  alu_control_o = ALU_OR;
            3'b111:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: state register, sticky illegal flag and Moore output
// decode; only the fetch/branch strobes look at mem_ready/zero directly.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int IGNORE_READY = 0
)
(
    input logic              clk,
    input logic              reset,
    multicycle_ctrl_if.slave bus
);

    state_t     state_q, state_d;
    logic       illegal_q;
    logic       ready;
    logic       sub_req;
    logic [2:0] alu_dec;

    logic       pc_write_w, adr_src_w, mem_write_w, mem_req_w, ir_write_w, reg_write_w;
    logic [1:0] result_src_w, alu_src_a_w, alu_src_b_w;
    logic [2:0] alu_control_w;

    assign ready   = (IGNORE_READY != 0) ? 1'b1 : bus.mem_ready;
    assign sub_req = (state_q == EXECUTER) & bus.op[5] & bus.funct7b5;

    alu_decoder u_alu_decoder (
        .funct3_i      (bus.funct3),
        .sub_req_i     (sub_req),
        .alu_control_o (alu_dec)
    );

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = HALT;
                endcase
            end
            MEMADR:   state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = ready ? FETCH : MEMWRITE;
            MEMWB:    state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT)
                illegal_q <= 1'b1;
        end
    end

    // Reset forces every strobe low combinationally, even though FETCH would request memory.
    always_comb begin
        pc_write_w    = 1'b0;
        adr_src_w     = 1'b0;
        mem_write_w   = 1'b0;
        mem_req_w     = 1'b0;
        ir_write_w    = 1'b0;
        reg_write_w   = 1'b0;
        result_src_w  = RES_ALUOUT;
        alu_src_a_w   = SRCA_PC;
        alu_src_b_w   = SRCB_RS2;
        alu_control_w = ALU_ADD;
        case (state_q)
            FETCH: begin
                mem_req_w    = 1'b1;
                alu_src_b_w  = SRCB_FOUR;
                result_src_w = RES_ALURESULT;
                ir_write_w   = ready;
                pc_write_w   = ready;
            end
            DECODE: begin
                alu_src_a_w = SRCA_OLDPC;
                alu_src_b_w = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a_w = SRCA_RS1;
                alu_src_b_w = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req_w = 1'b1;
                adr_src_w = 1'b1;
            end
            MEMWRITE: begin
                mem_req_w   = 1'b1;
                adr_src_w   = 1'b1;
                mem_write_w = 1'b1;
            end
            MEMWB: begin
                result_src_w = RES_DATA;
                reg_write_w  = 1'b1;
            end
            EXECUTER: begin
                alu_src_a_w   = SRCA_RS1;
                alu_control_w = alu_dec;
            end
            EXECUTEI: begin
                alu_src_a_w   = SRCA_RS1;
                alu_src_b_w   = SRCB_IMM;
                alu_control_w = alu_dec;
            end
            ALUWB: reg_write_w = 1'b1;
            BEQ: begin
                alu_src_a_w   = SRCA_RS1;
                alu_control_w = ALU_SUB;
                pc_write_w    = bus.zero;
            end
            JAL: begin
                alu_src_a_w = SRCA_OLDPC;
                alu_src_b_w = SRCB_FOUR;
                pc_write_w  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pc_write_w    = 1'b0;
            adr_src_w     = 1'b0;
            mem_write_w   = 1'b0;
            mem_req_w     = 1'b0;
            ir_write_w    = 1'b0;
            reg_write_w   = 1'b0;
            result_src_w  = RES_ALUOUT;
            alu_src_a_w   = SRCA_PC;
            alu_src_b_w   = SRCB_RS2;
            alu_control_w = ALU_ADD;
        end
    end

    assign bus.pc_write    = pc_write_w;
    assign bus.adr_src     = adr_src_w;
    assign bus.mem_write   = mem_write_w;
    assign bus.mem_req     = mem_req_w;
    assign bus.ir_write    = ir_write_w;
    assign bus.reg_write   = reg_write_w;
    assign bus.result_src  = result_src_w;
    assign bus.alu_src_a   = alu_src_a_w;
    assign bus.alu_src_b   = alu_src_b_w;
    assign bus.alu_control = alu_control_w;
    assign bus.imm_src     = imm_src_of(bus.op);
    assign bus.illegal     = illegal_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       mem_req;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    int     checkCount = 0;
    int     errorCount = 0;
    state_t mState = FETCH;

    logic [3:0] lwSeq [5];
    logic [3:0] lwExp [5] = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
    logic [2:0] f3List [4] = '{3'b010, 3'b110, 3'b111, 3'b100};

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.IGNORE_READY(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [1:0] modelImm(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] modelAlu(input logic [2:0] f3, input logic subtract);
        case (f3)
            3'b000:  return subtract ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic state_t modelNext(input state_t s, input logic [6:0] o, input logic rdy);
        case (s)
            FETCH:    return rdy ? DECODE : FETCH;
            DECODE: begin
                if (o == 7'b0000011 || o == 7'b0100011) return MEMADR;
                if (o == 7'b0110011) return EXECUTER;
                if (o == 7'b0010011) return EXECUTEI;
                if (o == 7'b1100011) return BEQ;
                if (o == 7'b1101111) return JAL;
                return HALT;
            end
            MEMADR:   return o[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  return rdy ? MEMWB : MEMREAD;
            MEMWRITE: return rdy ? FETCH : MEMWRITE;
            EXECUTER: return ALUWB;
            EXECUTEI: return ALUWB;
            JAL:      return ALUWB;
            HALT:     return HALT;
            default:  return FETCH;
        endcase
    endfunction

    function automatic outs_t modelOut(input state_t s, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z, input logic rdy);
        outs_t e;
        e = '0;
        e.state   = s;
        e.imm_src = modelImm(o);
        e.illegal = (s == HALT);
        case (s)
            FETCH:    begin e.mem_req = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                            e.ir_write = rdy; e.pc_write = rdy; end
            DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
            MEMWRITE: begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; end
            MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1; end
            EXECUTER: begin e.alu_src_a = 2'b10; e.alu_control = modelAlu(f3, o[5] & f7); end
            EXECUTEI: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = modelAlu(f3, 1'b0); end
            ALUWB:    e.reg_write = 1;
            BEQ:      begin e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z; end
            JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)
            mState <= FETCH;
        else
            mState <= modelNext(mState, bus.op, bus.mem_ready);
    end

    // Every falling edge: outputs against the model; under reset only strobes, state and illegal matter.
    always @(negedge clk) begin : compareBlock
        outs_t actOut;
        outs_t expOut;
        actOut = {bus.pc_write, bus.adr_src, bus.mem_write, bus.mem_req, bus.ir_write, bus.reg_write,
                  bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control,
                  bus.illegal, bus.state};
        expOut = modelOut(mState, bus.op, bus.funct3, bus.funct7b5, bus.zero, bus.mem_ready);
        if (reset) begin
            expOut = '0;
            expOut.state = FETCH;
            actOut.result_src  = '0;
            actOut.alu_src_a   = '0;
            actOut.alu_src_b   = '0;
            actOut.imm_src     = '0;
            actOut.alu_control = '0;
        end
        checkCount++;
        if (actOut !== expOut) begin
            errorCount++;
            $display("[TB] FAIL cycleOutputs t=%0t state=%0d got %h want %h", $time, mState, actOut, expOut);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] opV, input logic [2:0] f3V, input logic f7V,
                                 input logic zeroV, input logic readyV);
        #1;
        bus.op        = opV;
        bus.funct3    = f3V;
        bus.funct7b5  = f7V;
        bus.zero      = zeroV;
        bus.mem_ready = readyV;
    endtask

    task automatic runTo(input state_t target, input string name);
        int n = 0;
        while (bus.state !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(bus.state), 32'(target));
    endtask

    initial begin
        #100000;
        errorCount++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        int rwCount;
        int wCount;
        int haltCount;
        logic [4:0] rwMask;
        logic [1:0] swImm;

        bus.op = OP_LOAD; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("resetState", 32'(bus.state), 32'(FETCH));
        checkOutput("resetMemReq", 32'(bus.mem_req), 32'd0);
        checkOutput("resetIllegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;

        // lw with memory always ready
        #1;
        lwSeq[0] = bus.state;
        rwMask = 5'b0;
        rwMask[0] = bus.reg_write;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            lwSeq[i] = bus.state;
            rwMask[i] = bus.reg_write;
        end
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("lwState%0d", i), 32'(lwSeq[i]), 32'(lwExp[i]));
        checkOutput("lwRegWriteOnlyMemWb", 32'(rwMask), 32'b10000);
        @(negedge clk);
        checkOutput("lwBackToFetch", 32'(bus.state), 32'(FETCH));

        // sw stalled three cycles in MEMWRITE
        applyStimulus(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("swDecode", 32'(bus.state), 32'(DECODE));
        rwCount = bus.reg_write;
        wCount = 0;
        swImm = 2'b00;
        #1 bus.mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wCount  += bus.mem_write;
            rwCount += bus.reg_write;
            if (i == 1) swImm = bus.imm_src;
            if (i == 4) #1 bus.mem_ready = 1'b1;
        end
        checkOutput("swMemWriteCycles", 32'(wCount), 32'd4);
        checkOutput("swNoRegWrite", 32'(rwCount), 32'd0);
        checkOutput("swImmSrc", 32'(swImm), 32'b01);
        checkOutput("swBackToFetch", 32'(bus.state), 32'(FETCH));

        // beq taken and not taken
        applyStimulus(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1);
        runTo(BEQ, "beqTakenReach");
        checkOutput("beqTakenPcWrite", 32'(bus.pc_write), 32'd1);
        checkOutput("beqImmSrc", 32'(bus.imm_src), 32'b10);
        checkOutput("beqAluSub", 32'(bus.alu_control), 32'b001);
        runTo(FETCH, "beqTakenDone");
        applyStimulus(OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1);
        runTo(BEQ, "beqNotTakenReach");
        checkOutput("beqNotTakenPcWrite", 32'(bus.pc_write), 32'd0);
        runTo(FETCH, "beqNotTakenDone");

        // R-type sub versus addi with funct7b5 set
        applyStimulus(OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b1);
        runTo(EXECUTER, "subReach");
        checkOutput("subAlu", 32'(bus.alu_control), 32'b001);
        runTo(FETCH, "subDone");
        applyStimulus(OP_ITYPE, 3'b000, 1'b1, 1'b0, 1'b1);
        runTo(EXECUTEI, "addiReach");
        checkOutput("addiAlu", 32'(bus.alu_control), 32'b000);
        runTo(FETCH, "addiDone");
        foreach (f3List[k]) begin
            applyStimulus(OP_RTYPE, f3List[k], 1'b1, 1'b0, 1'b1);
            runTo(EXECUTER, $sformatf("rtypeReach%0d", k));
            if (k == 1) checkOutput("orAlu", 32'(bus.alu_control), 32'b011);
            runTo(FETCH, $sformatf("rtypeDone%0d", k));
        end

        // jal writes PC and then links through ALUWB
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
        runTo(JAL, "jalReach");
        checkOutput("jalPcWrite", 32'(bus.pc_write), 32'd1);
        runTo(ALUWB, "jalLink");
        checkOutput("jalRegWrite", 32'(bus.reg_write), 32'd1);
        runTo(FETCH, "jalDone");

        // lw with stalls in FETCH and MEMREAD
        applyStimulus(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("fetchStallState", 32'(bus.state), 32'(FETCH));
        checkOutput("fetchStallIrWrite", 32'(bus.ir_write), 32'd0);
        #1 bus.mem_ready = 1'b1;
        runTo(MEMADR, "lwStallMemAdr");
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("memReadHold", 32'(bus.state), 32'(MEMREAD));
        #1 bus.mem_ready = 1'b1;
        runTo(MEMWB, "lwStallMemWb");
        runTo(FETCH, "lwStallDone");

        // illegal opcode parks in HALT until reset
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        runTo(HALT, "haltReach");
        haltCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.state == HALT && bus.illegal == 1'b1) haltCount++;
        end
        checkOutput("haltHeld", 32'(haltCount), 32'd10);
        #1 reset = 1'b1;
        #1;
        checkOutput("haltResetState", 32'(bus.state), 32'(FETCH));
        checkOutput("haltResetIllegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;

        // asynchronous reset in the middle of a store
        applyStimulus(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1);
        runTo(DECODE, "abortDecode");
        #1 bus.mem_ready = 1'b0;
        runTo(MEMWRITE, "abortMemWrite");
        checkOutput("preAbortMemWrite", 32'(bus.mem_write), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("abortMemWriteDrop", 32'(bus.mem_write), 32'd0);
        checkOutput("abortMemReqDrop", 32'(bus.mem_req), 32'd0);
        checkOutput("abortState", 32'(bus.state), 32'(FETCH));
        @(negedge clk);
        #1;
        reset = 1'b0;
        bus.op = OP_ITYPE;
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("restartFetch", 32'(bus.state), 32'(FETCH));
        wCount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wCount += bus.mem_write;
        end
        checkOutput("noReissuedWrite", 32'(wCount), 32'd0);
        @(negedge clk);
        checkOutput("restartComplete", 32'(bus.state), 32'(FETCH));

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
